// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default reset PC and the fetch entry record.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Circular buffer of fetch entries with occupancy count; clr_i empties it in one cycle.
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Entry storage; contents are never observed while the count is zero.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) begin
      mem_r[wr_ptr_r] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clr_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata_o = mem_r[rd_ptr_r];
  assign count_o = count_r;
  assign full_o  = (count_r == CW'(DEPTH));
  assign empty_o = (count_r == CW'(0));

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetch PC, redirect flush and decode-side handshake.
// Optional same-cycle bypass of an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  output logic [31:0]                imem_addr_o,
  input  logic [31:0]                imem_instr_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  input  logic                       deq_ready_i,
  output logic                       deq_valid_o,
  output logic [31:0]                deq_pc_o,
  output logic [31:0]                deq_instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fpc_r;
  fetch_entry_t    fetch_s;
  fetch_entry_t    head_s;
  fetch_entry_t    deq_entry_s;
  logic [CW-1:0]   fifo_count_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            bypass_s;
  logic            valid_s;
  logic            hs_s;
  logic            advance_s;
  logic            push_s;
  logic            pop_s;

  assign fetch_s = '{pc: fpc_r, instr: imem_instr_i};

  // Handshake, push/pop and head selection; rst_n_i gating keeps a bypassed head silent in reset.
  always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s = fifo_empty_s & ~redirect_i & rst_n_i;
`else
    bypass_s = 1'b0;
`endif
    valid_s   = rst_n_i & ~redirect_i & (~fifo_empty_s | bypass_s);
    hs_s      = valid_s & deq_ready_i;
    advance_s = ~redirect_i & (~fifo_full_s | hs_s);
    push_s    = advance_s & ~(bypass_s & hs_s);
    pop_s     = hs_s & ~fifo_empty_s;
    if (bypass_s) begin
      deq_entry_s = fetch_s;
    end else if (!fifo_empty_s) begin
      deq_entry_s = head_s;
    end else begin
      deq_entry_s = '0;
    end
  end

  // Fetch PC: redirect wins, otherwise step by one word whenever the fetch is consumed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fpc_r <= RESET_PC;
    end else if (redirect_i) begin
      fpc_r <= redirect_pc_i;
    end else if (advance_s) begin
      fpc_r <= fpc_r + 32'd4;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (redirect_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (fetch_s),
    .rdata_o (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign imem_addr_o = fpc_r;
  assign deq_valid_o = valid_s;
  assign deq_pc_o    = deq_entry_s.pc;
  assign deq_instr_o = deq_entry_s.instr;
  assign count_o     = fifo_count_s;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of 2, >= 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr_o  output  32  fetch address to the instruction memory.
REQ-006 SHALL have port imem_instr_i  input  32  instruction at imem_addr_o, combinational, same cycle.
REQ-007 SHALL have port redirect_i  input  1  taken branch from the decode stage; flushes the queue.
REQ-008 SHALL have port redirect_pc_i  input  32  branch target, sampled when redirect_i = 1.
REQ-009 SHALL have port deq_ready_i  input  1  decode stage accepts head (not stalled).
REQ-010 SHALL have port deq_valid_o  output  1  head entry valid.
REQ-011 SHALL have port deq_pc_o  output  32  PC of head entry.
REQ-012 SHALL have port deq_instr_o  output  32  instruction of head entry.
REQ-013 SHALL have port count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-014 SHALL hold fetch PC register fpc; imem_addr_o = fpc.
REQ-015 SHALL push {fpc, imem_instr_i} and set fpc <= fpc + 4 (mod 2^32) each cycle where redirect_i = 0 and (count_o < DEPTH or a dequeue handshake occurs that cycle).
REQ-016 SHALL, when full with no dequeue, neither push nor advance fpc.
REQ-017 SHALL complete a dequeue handshake when deq_valid_o = 1 and deq_ready_i = 1; the head is then removed at the edge.
REQ-018 SHALL drive deq_valid_o = (count_o != 0) and redirect_i = 0; redirect_i forces deq_valid_o = 0 combinationally.
REQ-019 SHALL, on redirect_i = 1, set count_o <= 0, reset both pointers, set fpc <= redirect_pc_i, perform no push and no dequeue.
REQ-020 SHALL support simultaneous push and dequeue: count unchanged, both pointers advance.
REQ-021 SHALL wrap read/write pointers modulo DEPTH.
REQ-022 SHALL hold deq_pc_o/deq_instr_o stable while deq_valid_o = 1 and deq_ready_i = 0.
REQ-023 SHALL give a latency of one cycle: instruction fetched in cycle N is at head in cycle N+1 if the queue was empty.
REQ-024 SHALL, after redirect in cycle N, fetch redirect_pc_i in cycle N+1, valid at head in cycle N+2.

Reset
REQ-025 SHALL, while rst_n_i = 0, force fpc = RESET_PC, count_o = 0, pointers = 0, deq_valid_o = 0, deq_pc_o = 0, deq_instr_o = 0, regardless of clock.
REQ-026 SHALL discard all entries on reset asserted mid-operation; first push on first rising edge after release.

Configuration
REQ-027 SHALL, with FETCH_QUEUE_BYPASS_EN defined, present {fpc, imem_instr_i} directly on deq outputs with deq_valid_o = 1 when the queue is empty and redirect_i = 0; if accepted, no push occurs, fpc advances.
REQ-028 SHALL, without FETCH_QUEUE_BYPASS_EN, never bypass; REQ-023/REQ-024 latencies apply.
REQ-029 SHALL, with bypass, reduce REQ-023 latency to 0 and REQ-024 to 1 cycle.

Structure
REQ-030 SHALL take XLEN (32), RESET_PC default and typedef fetch_entry_t {pc, instr} from shared package cpu_pkg.
REQ-031 SHALL instantiate one sub-module sync_fifo (fetch_entry_t storage, pointers, count); PC/redirect/bypass logic in fetch_queue.

Verification
REQ-032 SHALL cover reset release, deq_ready_i = 1, imem returns addr ^ 32'hAAAA_0000 -> heads 0x0,0x4,0x8 with matching instr, first valid one cycle after release (no bypass).
REQ-033 SHALL cover deq_ready_i = 0 for 10 cycles, DEPTH=4 -> count_o = 4, fpc = 0x10 frozen, head pc 0x0 stable.
REQ-034 SHALL cover full queue, deq_ready_i = 1 one cycle -> count_o stays 4, head pc 0x4, fpc = 0x14.
REQ-035 SHALL cover redirect_i = 1 with redirect_pc_i = 0x100 while count_o = 3 -> deq_valid_o = 0 that cycle, count_o = 0 next, head pc 0x100 two cycles after redirect.
REQ-036 SHALL cover rst_n_i pulsed low mid-cycle with count_o = 2 -> outputs zero immediately, fpc = RESET_PC, no clock edge needed.
REQ-037 SHALL cover FETCH_QUEUE_BYPASS_EN with empty queue, deq_ready_i = 1 -> deq_pc_o = fpc same cycle, count_o stays 0.
